// File: rtl/fetch_sequencer_if.sv
// Bundle between the UART byte stream, the fetch stage and the instruction-memory write port.
interface fetch_sequencer_if #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 13
);
  localparam int ADDR = $clog2(MAX_INSTRUCTION);

  logic [7:0]      i_rx_data;
  logic            i_rx_valid;
  logic            i_halt;
  logic            o_stall;
  logic            o_pipe_rst;
  logic            o_imem_we;
  logic [ADDR-1:0] o_imem_addr;
  logic [SIZE-1:0] o_imem_data;
  logic [ADDR:0]   o_prog_len;
  logic            o_busy;
  logic            o_err;

  modport master (
    input  i_rx_data, i_rx_valid, i_halt,
    output o_stall, o_pipe_rst, o_imem_we, o_imem_addr, o_imem_data,
           o_prog_len, o_busy, o_err
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_halt,
    input  o_stall, o_pipe_rst, o_imem_we, o_imem_addr, o_imem_data,
           o_prog_len, o_busy, o_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Byte-command controller: loads instruction memory from a UART byte stream and
// gates the fetch stage with run / step / halt commands.
module fetch_sequencer #(
  parameter int SIZE            = 32,
  parameter int MAX_INSTRUCTION = 13
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);
  localparam int ADDR = $clog2(MAX_INSTRUCTION);
  localparam logic [7:0] MAX_N   = 8'(MAX_INSTRUCTION);
  localparam logic [7:0] CMD_L   = 8'h4C;
  localparam logic [7:0] CMD_C   = 8'h43;
  localparam logic [7:0] CMD_S   = 8'h53;
  localparam logic [7:0] CMD_H   = 8'h48;

  typedef enum logic [2:0] {
    HALT, LOAD_CNT, LOAD_BYTE, PIPE_RST, RUN, STEP
  } state_t;

  state_t          state, state_next;
  logic [ADDR:0]   n_words;
  logic [ADDR-1:0] word_idx;
  logic [1:0]      byte_cnt;
  logic [23:0]     shift;

  logic err_next, cnt_ok, byte_take, word_done, last_word;

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    cnt_ok     = 1'b0;
    byte_take  = 1'b0;
    word_done  = 1'b0;
    last_word  = 1'b0;
    case (state)
      HALT: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            CMD_L:   state_next = LOAD_CNT;
            CMD_C:   state_next = RUN;
            CMD_S:   state_next = STEP;
            CMD_H:   state_next = HALT;
            default: err_next   = 1'b1;
          endcase
        end
      end
      LOAD_CNT: begin
        if (bus.i_rx_valid) begin
          if (bus.i_rx_data != 8'd0 && bus.i_rx_data <= MAX_N) begin
            cnt_ok     = 1'b1;
            state_next = LOAD_BYTE;
          end else begin
            err_next   = 1'b1;
            state_next = HALT;
          end
        end
      end
      LOAD_BYTE: begin
        // every byte is payload here, command values included
        if (bus.i_rx_valid) begin
          byte_take = 1'b1;
          if (byte_cnt == 2'd3) begin
            word_done = 1'b1;
            if ({1'b0, word_idx} == n_words - 1'b1) begin
              last_word  = 1'b1;
              state_next = PIPE_RST;
            end
          end
        end
      end
      PIPE_RST: state_next = HALT;
      RUN: begin
        // a simultaneous 'H' and i_halt collapse into one halt, no error
        if (bus.i_rx_valid && bus.i_rx_data != CMD_H)
          err_next = 1'b1;
        if (bus.i_halt || (bus.i_rx_valid && bus.i_rx_data == CMD_H))
          state_next = HALT;
      end
      STEP:    state_next = HALT;
      default: state_next = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HALT;
      n_words         <= '0;
      word_idx        <= '0;
      byte_cnt        <= '0;
      shift           <= '0;
      bus.o_stall     <= 1'b1;
      bus.o_pipe_rst  <= 1'b0;
      bus.o_imem_we   <= 1'b0;
      bus.o_imem_addr <= '0;
      bus.o_imem_data <= '0;
      bus.o_prog_len  <= '0;
      bus.o_err       <= 1'b0;
    end else begin
      state          <= state_next;
      bus.o_stall    <= !(state_next == RUN || state_next == STEP);
      bus.o_pipe_rst <= (state_next == PIPE_RST);
      bus.o_err      <= err_next;
      bus.o_imem_we  <= word_done;
      if (cnt_ok) begin
        n_words  <= bus.i_rx_data[ADDR:0];
        word_idx <= '0;
        byte_cnt <= '0;
      end
      if (byte_take) begin
        shift    <= {shift[15:0], bus.i_rx_data};
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (word_done) begin
        bus.o_imem_data <= {shift, bus.i_rx_data};
        bus.o_imem_addr <= word_idx;
        word_idx        <= word_idx + 1'b1;
      end
      if (last_word)
        bus.o_prog_len <= n_words;
    end
  end

  assign bus.o_busy = (state == LOAD_CNT) || (state == LOAD_BYTE) || (state == RUN);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, loads, bad counts, step, run/halt, reset mid-word.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.SIZE(32), .MAX_INSTRUCTION(13)) bif ();

  fetch_sequencer #(.SIZE(32), .MAX_INSTRUCTION(13)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // apply inputs across one posedge; return at the next negedge with updated outputs
  task automatic cyc(input logic v, input logic [7:0] d, input logic h, input logic r);
    bif.i_rx_valid = v;
    bif.i_rx_data  = d;
    bif.i_halt     = h;
    rst            = r;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"},    32'(bif.o_stall),     32'd1);
    chk({tag, "_piperst"},  32'(bif.o_pipe_rst),  32'd0);
    chk({tag, "_we"},       32'(bif.o_imem_we),   32'd0);
    chk({tag, "_addr"},     32'(bif.o_imem_addr), 32'd0);
    chk({tag, "_data"},     bif.o_imem_data,      32'd0);
    chk({tag, "_proglen"},  32'(bif.o_prog_len),  32'd0);
    chk({tag, "_busy"},     32'(bif.o_busy),      32'd0);
    chk({tag, "_err"},      32'(bif.o_err),       32'd0);
  endtask

  initial begin
    logic [7:0]  b0, b3;
    int unsigned lows;

    bif.i_rx_valid = 1'b0;
    bif.i_rx_data  = 8'h00;
    bif.i_halt     = 1'b0;
    @(negedge clk);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk_reset_outputs("reset");
    idle();

    // run then halt by command
    send(8'h43);
    chk("run_stall", 32'(bif.o_stall), 32'd0);
    chk("run_busy",  32'(bif.o_busy),  32'd1);
    send(8'h48);
    chk("haltcmd_stall", 32'(bif.o_stall), 32'd1);
    chk("haltcmd_busy",  32'(bif.o_busy),  32'd0);

    // two-word load, bytes back to back
    send(8'h4C);
    chk("ld_busy", 32'(bif.o_busy), 32'd1);
    send(8'h02);
    send(8'h3C); send(8'h01); send(8'h00);
    chk("ld_w0_early_we", 32'(bif.o_imem_we), 32'd0);
    send(8'h01);
    chk("ld_w0_we",   32'(bif.o_imem_we),   32'd1);
    chk("ld_w0_addr", 32'(bif.o_imem_addr), 32'd0);
    chk("ld_w0_data", bif.o_imem_data,      32'h3C010001);
    chk("ld_w0_prst", 32'(bif.o_pipe_rst),  32'd0);
    send(8'h00);
    chk("ld_we_pulse", 32'(bif.o_imem_we), 32'd0);
    send(8'h00); send(8'h00); send(8'h00);
    chk("ld_w1_we",    32'(bif.o_imem_we),   32'd1);
    chk("ld_w1_addr",  32'(bif.o_imem_addr), 32'd1);
    chk("ld_w1_data",  bif.o_imem_data,      32'h00000000);
    chk("ld_w1_prst",  32'(bif.o_pipe_rst),  32'd1);
    chk("ld_proglen",  32'(bif.o_prog_len),  32'd2);
    chk("ld_stall",    32'(bif.o_stall),     32'd1);
    idle();
    chk("ld_prst_pulse", 32'(bif.o_pipe_rst), 32'd0);
    chk("ld_done_busy",  32'(bif.o_busy),     32'd0);

    // bad counts
    send(8'h4C); send(8'h00);
    chk("cnt0_err",  32'(bif.o_err),  32'd1);
    chk("cnt0_busy", 32'(bif.o_busy), 32'd0);
    idle();
    chk("cnt0_err_pulse", 32'(bif.o_err), 32'd0);
    send(8'h4C); send(8'd14);
    chk("cnt14_err",  32'(bif.o_err),  32'd1);
    chk("cnt14_busy", 32'(bif.o_busy), 32'd0);
    idle();

    // maximum-length load, 'L'/'C' bytes inside data treated as payload
    send(8'h4C); send(8'd13);
    for (int unsigned w = 0; w < 13; w++) begin
      b0 = 8'(w);
      b3 = (w == 5) ? 8'h43 : 8'(w * 3);
      send(b0); send(8'h4C); send(8'h00); send(b3);
      chk($sformatf("max_w%0d_we", w),   32'(bif.o_imem_we),   32'd1);
      chk($sformatf("max_w%0d_addr", w), 32'(bif.o_imem_addr), w);
      chk($sformatf("max_w%0d_data", w), bif.o_imem_data,      {b0, 8'h4C, 8'h00, b3});
      chk($sformatf("max_w%0d_prst", w), 32'(bif.o_pipe_rst),  (w == 12) ? 32'd1 : 32'd0);
    end
    chk("max_proglen", 32'(bif.o_prog_len), 32'd13);
    idle();

    // unknown byte in HALT
    send(8'h7F);
    chk("halt_bad_err", 32'(bif.o_err), 32'd1);
    idle();
    chk("halt_bad_err_pulse", 32'(bif.o_err), 32'd0);

    // single step
    send(8'h53);
    chk("step_low",  32'(bif.o_stall), 32'd0);
    chk("step_busy", 32'(bif.o_busy),  32'd0);
    idle();
    chk("step_high", 32'(bif.o_stall), 32'd1);
    lows = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      send(8'h53);
      if (bif.o_stall == 1'b0) lows++;
      idle();
      if (bif.o_stall == 1'b0) lows++;
      idle();
      if (bif.o_stall == 1'b0) lows++;
    end
    chk("step3_lows", lows, 32'd3);

    // run stopped by i_halt
    send(8'h43);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ihalt_stall", 32'(bif.o_stall), 32'd1);
    chk("ihalt_busy",  32'(bif.o_busy),  32'd0);
    idle();
    chk("ihalt_hold", 32'(bif.o_stall), 32'd1);

    // bad command during run, then 'H' together with i_halt
    send(8'h43);
    send(8'h53);
    chk("run_s_err",   32'(bif.o_err),   32'd1);
    chk("run_s_stall", 32'(bif.o_stall), 32'd0);
    idle();
    chk("run_s_err_pulse", 32'(bif.o_err),   32'd0);
    chk("run_s_still",     32'(bif.o_stall), 32'd0);
    cyc(1'b1, 8'h48, 1'b1, 1'b0);
    chk("both_halt_stall", 32'(bif.o_stall), 32'd1);
    chk("both_halt_err",   32'(bif.o_err),   32'd0);

    // i_halt in HALT is ignored; run still works afterwards
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ihalt_idle_err", 32'(bif.o_err), 32'd0);
    send(8'h43);
    chk("rerun_stall", 32'(bif.o_stall), 32'd0);
    send(8'h48);

    // reset after the second byte of a word
    send(8'h4C); send(8'h01); send(8'hAA); send(8'hBB);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk_reset_outputs("midrst");
    send(8'hCC); send(8'hDD);
    chk("midrst_nowrite", 32'(bif.o_imem_we), 32'd0);
    chk("midrst_err",     32'(bif.o_err),     32'd1);
    idle();
    send(8'h43);
    chk("midrst_run", 32'(bif.o_stall), 32'd0);
    send(8'h48);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Byte-command controller for the instruction fetch stage and its instruction memory. It takes a byte stream from the UART receiver and decodes four commands: program load, continuous run, single step and halt. It writes 32-bit words into instruction memory, drives the fetch stage's stall input and issues a one-cycle pipeline reset after each load. It sits between the UART RX and the fetch stage / instruction memory write port.

## Interface
- SIZE, 32: instruction word width (fixed 32; loaded as 4 bytes).
- MAX_INSTRUCTION, 13: instruction memory depth in words; address width ADDR = $clog2(MAX_INSTRUCTION).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle.
- i_halt  in  1  pipeline reached halt instruction (level, sampled each cycle).
- o_stall  out  1  to fetch i_stall; 1 = PC frozen.
- o_pipe_rst  out  1  one-cycle pulse resetting PC/pipeline after load.
- o_imem_we  out  1  instruction memory write enable (one-cycle pulse per word).
- o_imem_addr  out  ADDR  write word address.
- o_imem_data  out  SIZE  write word.
- o_prog_len  out  ADDR+1  word count of last successful load.
- o_busy  out  1  1 in any LOAD state or RUN.
- o_err  out  1  one-cycle pulse on protocol error.

## Operation
- States: HALT, LOAD_CNT, LOAD_BYTE, PIPE_RST, RUN, STEP.
- Commands (byte value): 'L' 0x4C load, 'C' 0x43 run, 'S' 0x53 step, 'H' 0x48 halt.
- HALT: o_stall=1.
  - 'L' goes to LOAD_CNT.
  - 'C' goes to RUN.
  - 'S' goes to STEP.
  - 'H' is accepted with no effect.
  - Any other byte pulses o_err and stays in HALT.
- LOAD_CNT: the next byte is N.
  - If 1 ≤ N ≤ MAX_INSTRUCTION: latch N, clear the word index and byte count, go to LOAD_BYTE.
  - Otherwise: pulse o_err and return to HALT.
- LOAD_BYTE: bytes are shifted in MSB-first, so the first byte lands in [31:24].
  - On the 4th byte: register o_imem_data (the assembled word) and o_imem_addr (the word index), pulse o_imem_we in the next cycle, and increment the word index.
  - Byte collection continues during the write cycle, so no byte is lost.
  - After word N-1 is written: set o_prog_len=N and go to PIPE_RST.
  - Command bytes are not decoded while loading; every byte is data.
- PIPE_RST: o_pipe_rst=1 for exactly one cycle, o_stall stays 1, then go to HALT.
- RUN: o_stall=0.
  - 'H' or i_halt=1 makes o_stall=1 from the next cycle and returns to HALT.
  - Any other byte pulses o_err and is otherwise ignored.
- STEP: o_stall=0 for exactly one cycle (PC advances once), then return to HALT.
- o_stall is a registered, decoded output: 1 in every state except RUN and STEP.
- A 'C' or 'S' before any load is legal; the fetch stage runs whatever memory holds.

## Timing
- Reset values: o_stall=1, o_pipe_rst=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, o_prog_len=0, o_busy=0, o_err=0, state=HALT.
- rst mid-load: the partial word is discarded, no write is issued, and o_prog_len returns to 0.
- Command latency: a byte accepted at cycle t changes state at t+1, so the outputs reflect the new state at t+1.
  - 'C' at t gives o_stall=0 from t+1.
  - 'S' at t gives o_stall=0 at t+1 only.
- Write latency: 4th byte at t gives o_imem_we=1 at t+1, with addr/data stable that cycle.
- Last word: the 4th byte of word N-1 at t gives o_imem_we=1 and o_pipe_rst=1 both at t+1, then HALT at t+2.
- i_halt and 'H' in the same cycle are a single halt with no error.
- i_halt in HALT or STEP is ignored.
- o_err is always a single-cycle pulse, at t+1 after the offending byte.
- i_rx_valid on consecutive cycles must be handled; there is no backpressure.

## Test plan
- Reset: after rst, o_stall=1, all other outputs 0, and 'C' gives o_stall=0 one cycle later.
- Load 2 words: send 0x4C,0x02,0x3C,0x01,0x00,0x01,0x00,0x00,0x00,0x00.
  - Expect we at addr 0 with 0x3C010001, then addr 1 with 0x00000000.
  - Expect o_pipe_rst on the same cycle as the 2nd write, and o_prog_len=2.
- Bad counts: 0x4C,0x00 pulses o_err and returns to HALT. 0x4C followed by MAX_INSTRUCTION+1 (14) does the same.
- Step: 'S' at t gives o_stall=0 only at t+1 and 1 at t+2; three 'S' give exactly three stall-low cycles.
- Run/halt: 'C' then i_halt=1 at t gives o_stall=1 at t+1. 'C' then 'H' does the same. 'S' during RUN pulses o_err and stalls nothing.
- Back-to-back bytes with rst mid-word: an 'L' load with i_rx_valid every cycle writes correctly. rst asserted after the 2nd byte of a word produces no write and returns outputs to reset values.
